// File: rtl/axis_cpu_loader.sv
// axis_cpu_loader: unpacks a sectioned config stream into the CPU's instruction, immediate and jump tables.
// Define AXIS_CPU_LOADER_CHECKSUM_EN to require a summed trailer word after END.
module axis_cpu_loader #(
  parameter int CODE_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                prog_TDATA,
  input  logic                       prog_TVALID,
  output logic                       prog_TREADY,
  input  logic                       prog_TLAST,
  output logic [CODE_ADDR_WIDTH-1:0] inst_mem_wr_addr,
  output logic [7:0]                 inst_mem_wr_data,
  output logic                       inst_mem_wr_en,
  output logic [3:0]                 imm_wr_addr,
  output logic [31:0]                imm_wr_data,
  output logic                       imm_wr_en,
  output logic [3:0]                 jmp_off_wr_addr,
  output logic [7:0]                 jmp_off_wr_data,
  output logic                       jmp_off_wr_en,
  output logic                       cpu_hold,
  output logic                       load_done,
  output logic                       load_err
);
  typedef enum logic [2:0] {IDLE, HEADER, INST, IMM, JMP, DRAIN, DONE, CSUM} state_t;
  state_t state, state_nx;
  logic [15:0] left;
  logic [CODE_ADDR_WIDTH-1:0] addr;
  logic [23:0] pack;
  logic [1:0] rem;
  logic first, acc, over, err, done, pk_acc, byte_go;
  logic [2:0] n;
  logic [7:0] byte_val;
  logic [1:0] typ;
  logic [15:0] cnt;
  logic [13:0] unused_hdr;
  assign typ = prog_TDATA[31:30];
  assign cnt = prog_TDATA[15:0];
  assign unused_hdr = prog_TDATA[29:16];
  // rem counts bytes still queued behind the one currently on the write port
  assign prog_TREADY = state == HEADER || state == IMM || state == DRAIN || state == CSUM ||
                       ((state == INST || state == JMP) && rem == 2'd0);
  assign acc = prog_TVALID && prog_TREADY;
  assign pk_acc = acc && !prog_TLAST && (state == INST || state == JMP);
  assign n = left >= 16'd4 ? 3'd4 : left[2:0];
  assign byte_go = pk_acc || rem != 2'd0;
  assign byte_val = pk_acc ? prog_TDATA[7:0] : pack[7:0];
  assign over = typ == 2'b00 ? 32'(cnt) > (32'd1 << CODE_ADDR_WIDTH) : cnt > 16'd16;
`ifdef AXIS_CPU_LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic sum_ok, counted;
  assign sum_ok = sum == prog_TDATA;
  assign counted = (state == HEADER && typ != 2'b11) || state == INST || state == IMM || state == JMP;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum <= '0;
    else if (acc) sum <= (first ? 32'd0 : sum) + (counted ? prog_TDATA : 32'd0);
  end
`endif
  always_comb begin
    state_nx = state;
    err = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: state_nx = HEADER;
      HEADER: if (acc) begin
        if (typ == 2'b11) begin
`ifdef AXIS_CPU_LOADER_CHECKSUM_EN
          err = prog_TLAST;
          state_nx = prog_TLAST ? HEADER : CSUM;
`else
          done = prog_TLAST;
          err = !prog_TLAST;
          state_nx = prog_TLAST ? DONE : DRAIN;
`endif
        end else begin
          err = prog_TLAST || over;
          state_nx = prog_TLAST || cnt == 16'd0 ? HEADER : over ? DRAIN :
                     typ == 2'b00 ? INST : typ == 2'b01 ? IMM : JMP;
        end
      end
      INST, JMP: begin
        err = acc && prog_TLAST;
        if (acc) state_nx = prog_TLAST || left == 16'd1 ? HEADER : state;
        else if (left == 16'd0 && rem == 2'd1) state_nx = HEADER;
      end
      IMM: begin
        err = acc && prog_TLAST;
        if (acc && (prog_TLAST || left == 16'd1)) state_nx = HEADER;
      end
      DRAIN: if (acc && prog_TLAST) state_nx = HEADER;
      DONE: state_nx = HEADER;
      CSUM: if (acc) begin
`ifdef AXIS_CPU_LOADER_CHECKSUM_EN
        done = prog_TLAST && sum_ok;
        err = !done;
        state_nx = done ? DONE : prog_TLAST ? HEADER : DRAIN;
`else
        state_nx = HEADER;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      left <= '0;
      addr <= '0;
      pack <= '0;
      rem <= '0;
      first <= 1'b1;
      inst_mem_wr_addr <= '0;
      inst_mem_wr_data <= '0;
      inst_mem_wr_en <= 1'b0;
      imm_wr_addr <= '0;
      imm_wr_data <= '0;
      imm_wr_en <= 1'b0;
      jmp_off_wr_addr <= '0;
      jmp_off_wr_data <= '0;
      jmp_off_wr_en <= 1'b0;
      cpu_hold <= 1'b1;
      load_done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state <= state_nx;
      load_done <= done;
      inst_mem_wr_en <= byte_go && state == INST;
      jmp_off_wr_en <= byte_go && state == JMP;
      imm_wr_en <= acc && !prog_TLAST && state == IMM;
      if (acc) first <= prog_TLAST;
      if (acc && first && state == HEADER) begin
        cpu_hold <= 1'b1;
        load_err <= 1'b0;
      end
      if (err) load_err <= 1'b1;
      if (done) cpu_hold <= 1'b0;
      if (acc && state == HEADER) begin
        left <= cnt;
        addr <= '0;
      end
      if (byte_go) begin
        if (state == INST) begin
          inst_mem_wr_addr <= addr;
          inst_mem_wr_data <= byte_val;
        end else begin
          jmp_off_wr_addr <= addr[3:0];
          jmp_off_wr_data <= byte_val;
        end
        addr <= addr + 1'b1;
        pack <= pk_acc ? prog_TDATA[31:8] : pack >> 8;
        rem <= pk_acc ? 2'(n - 3'd1) : rem - 2'd1;
        if (pk_acc) left <= left - 16'(n);
      end
      if (acc && !prog_TLAST && state == IMM) begin
        imm_wr_addr <= addr[3:0];
        imm_wr_data <= prog_TDATA;
        addr <= addr + 1'b1;
        left <= left - 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_axis_cpu_loader.sv
// tb_axis_cpu_loader: directed and random packets checked against a per-packet reference model of the loader.
module tb_axis_cpu_loader;
  localparam int CAW = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] prog_TDATA = '0;
  logic prog_TVALID = 1'b0;
  logic prog_TLAST = 1'b0;
  logic prog_TREADY;
  logic [CAW-1:0] inst_mem_wr_addr;
  logic [7:0] inst_mem_wr_data, jmp_off_wr_data;
  logic [3:0] imm_wr_addr, jmp_off_wr_addr;
  logic [31:0] imm_wr_data;
  logic inst_mem_wr_en, imm_wr_en, jmp_off_wr_en, cpu_hold, load_done, load_err;

  axis_cpu_loader #(.CODE_ADDR_WIDTH(CAW)) dut (
    .clk(clk), .rst(rst),
    .prog_TDATA(prog_TDATA), .prog_TVALID(prog_TVALID), .prog_TREADY(prog_TREADY), .prog_TLAST(prog_TLAST),
    .inst_mem_wr_addr(inst_mem_wr_addr), .inst_mem_wr_data(inst_mem_wr_data), .inst_mem_wr_en(inst_mem_wr_en),
    .imm_wr_addr(imm_wr_addr), .imm_wr_data(imm_wr_data), .imm_wr_en(imm_wr_en),
    .jmp_off_wr_addr(jmp_off_wr_addr), .jmp_off_wr_data(jmp_off_wr_data), .jmp_off_wr_en(jmp_off_wr_en),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  typedef struct { int a; int d; } wr_t;
  wr_t gi[$], gm[$], gj[$], ei[$], em[$], ej[$];
  int ti[$];
  logic [32:0] pkt[$];
  int cyc = 0, dones = 0, errors = 0, checks = 0, last_len = 0;
  int kind, ns, t, c, idx;
  bit exp_done, exp_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!rst) begin
    if (inst_mem_wr_en) begin
      gi.push_back(wr_t'{int'(inst_mem_wr_addr), int'(inst_mem_wr_data)});
      ti.push_back(cyc);
    end
    if (imm_wr_en) gm.push_back(wr_t'{int'(imm_wr_addr), int'(imm_wr_data)});
    if (jmp_off_wr_en) gj.push_back(wr_t'{int'(jmp_off_wr_addr), int'(jmp_off_wr_data)});
    if (load_done) dones = dones + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [31:0] d, input logic l);
    pkt.push_back({l, d});
  endfunction

  function automatic void sec(input int st, input int sc, input int nw);
    push({st[1:0], 14'($urandom), sc[15:0]}, 1'b0);
    for (int w = 0; w < nw; w++) push($urandom, 1'b0);
  endfunction

  function automatic void end_pkt(input int bad);
`ifdef AXIS_CPU_LOADER_CHECKSUM_EN
    logic [31:0] s = '0;
    foreach (pkt[i]) s += pkt[i][31:0];
    push(32'hC000_0000, 1'b0);
    push(s + 32'(bad), 1'b1);
`else
    push({2'b11, 14'd0, 16'(bad)}, 1'b1);
`endif
  endfunction

  // Walks the packet section by section and lists the writes and outcome a correct loader produces.
  task automatic model();
    int i = 0, mc, mt, e;
    logic [31:0] h, w, s;
    logic l;
    s = '0;
    ei.delete(); em.delete(); ej.delete();
    exp_done = 0;
    exp_err = 0;
    while (i < pkt.size()) begin
      h = pkt[i][31:0];
      l = pkt[i][32];
      i++;
      mt = int'(h[31:30]);
      mc = int'(h[15:0]);
      if (mt == 3) begin
`ifdef AXIS_CPU_LOADER_CHECKSUM_EN
        if (l || i >= pkt.size()) exp_err = 1;
        else begin
          exp_done = pkt[i][32] && pkt[i][31:0] == s;
          exp_err = !exp_done;
        end
`else
        exp_done = l;
        exp_err = !l;
`endif
        return;
      end
      s += h;
      if (l || mc > (mt == 0 ? 1 << CAW : 16)) begin
        exp_err = 1;
        return;
      end
      e = 0;
      while (e < mc) begin
        w = pkt[i][31:0];
        l = pkt[i][32];
        i++;
        if (l) begin
          exp_err = 1;
          return;
        end
        s += w;
        if (mt == 1) begin
          em.push_back(wr_t'{e, int'(w)});
          e++;
        end else for (int b = 0; b < 4; b++) if (e < mc) begin
          if (mt == 0) ei.push_back(wr_t'{e, int'(w[8*b +: 8])});
          else ej.push_back(wr_t'{e, int'(w[8*b +: 8])});
          e++;
        end
      end
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    int k = 0;
    prog_TDATA = d;
    prog_TLAST = l;
    prog_TVALID = 1'b1;
    while (!prog_TREADY && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", k < 40, 1);
    @(negedge clk);
    prog_TVALID = 1'b0;
    prog_TLAST = 1'b0;
  endtask

  task automatic cmp_q(input string tag, input wr_t g[$], input wr_t e[$]);
    chk({tag, "_n"}, g.size(), e.size());
    foreach (e[i]) if (i < g.size()) begin
      chk($sformatf("%s_a%0d", tag, i), g[i].a, e[i].a);
      chk($sformatf("%s_d%0d", tag, i), g[i].d, e[i].d);
    end
  endtask

  task automatic run_pkt(input string tag);
    int c0;
    gi.delete(); gm.delete(); gj.delete(); ti.delete();
    dones = 0;
    c0 = cyc;
    foreach (pkt[i]) beat(pkt[i][31:0], pkt[i][32]);
    last_len = cyc - c0;
    repeat (3) @(negedge clk);
    model();
    cmp_q({tag, "_inst"}, gi, ei);
    cmp_q({tag, "_imm"}, gm, em);
    cmp_q({tag, "_jmp"}, gj, ej);
    chk({tag, "_done"}, dones, exp_done);
    chk({tag, "_err"}, load_err, exp_err);
    chk({tag, "_hold"}, cpu_hold, !exp_done);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", prog_TREADY, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_flags", {inst_mem_wr_en, imm_wr_en, jmp_off_wr_en, load_done, load_err}, 0);
    chk("rst_addr", {inst_mem_wr_addr, imm_wr_addr, jmp_off_wr_addr}, 0);
    chk("rst_data", {inst_mem_wr_data, imm_wr_data, jmp_off_wr_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    pkt.delete();
    push(32'h0000_0005, 1'b0); push(32'h4433_2211, 1'b0); push(32'h0000_0055, 1'b0); end_pkt(0);
    run_pkt("inst5");
    chk("inst5_burst", ti.size() == 5 ? ti[4] - ti[0] : -1, 4);
    chk("inst5_b4", gi.size() == 5 ? gi[4].d : -1, 'h55);

    pkt.delete();
    push(32'h4000_0002, 1'b0); push(32'hDEAD_BEEF, 1'b0); push(32'h1234_5678, 1'b0); end_pkt(0);
    run_pkt("imm2");
    chk("imm2_no_stall", last_len, pkt.size());
    chk("imm2_v1", gm.size() == 2 ? gm[1].d : 0, 32'h1234_5678);

    pkt.delete();
    push(32'h8000_0011, 1'b0); push($urandom, 1'b0); push($urandom, 1'b0); end_pkt(0);
    run_pkt("jmp17");

    pkt.delete();
    push(32'h4000_0003, 1'b0); push($urandom, 1'b0); push($urandom, 1'b1);
    run_pkt("imm_tlast");
    pkt.delete();
    sec(1, 1, 1); end_pkt(0);
    run_pkt("recover");

    pkt.delete();
    push(32'h0000_0028, 1'b0);
    for (int w = 0; w < 3; w++) push($urandom, 1'b0);
    foreach (pkt[i]) beat(pkt[i][31:0], pkt[i][32]);
    #2 rst = 1'b1;
    #1;
    chk("midrst_flags", {prog_TREADY, inst_mem_wr_en, load_done, load_err, cpu_hold}, 5'b00001);
    chk("midrst_inst", {inst_mem_wr_addr, inst_mem_wr_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pkt.delete();
    sec(0, 9, 3); sec(2, 6, 2); end_pkt(0);
    run_pkt("after_rst");

`ifdef AXIS_CPU_LOADER_CHECKSUM_EN
    pkt.delete();
    sec(1, 2, 2); end_pkt(1);
    run_pkt("csum_bad");
`endif

    for (int p = 0; p < 12; p++) begin
      pkt.delete();
      kind = $urandom_range(0, 3);
      ns = $urandom_range(1, 3);
      for (int s = 0; s < ns; s++) begin
        t = $urandom_range(0, 2);
        c = $urandom_range(0, t == 0 ? 20 : 16);
        if (kind == 2 && s == 0) sec(t, t == 0 ? (1 << CAW) + 1 : 17, 2);
        else sec(t, c, t == 1 ? c : (c + 3) / 4);
      end
      if (kind == 3) begin
        idx = $urandom_range(0, pkt.size() - 1);
        pkt[idx][32] = 1'b1;
        while (pkt.size() > idx + 1) void'(pkt.pop_back());
      end else end_pkt(0);
      run_pkt($sformatf("rnd%0d", p));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
